// File: rtl/btb_update_ctrl.sv
// Serialises BTB target-PC / target-instruction writes from two EX branch slots via a small FIFO.
// Optional BTBC_COALESCE_EN: pushes hitting a queued entry's index overwrite it instead of allocating.
module btb_update_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [31:0]      req0_pc,
  input  logic [31:0]      req0_target,
  input  logic             req1_valid,
  input  logic [31:0]      req1_pc,
  input  logic [31:0]      req1_target,
  output logic             req_ready,
  input  logic             flush,
  input  logic [31:0]      pc1_IF2,
  input  logic [31:0]      pc2_IF2,
  input  logic [31:0]      inst1_IF2,
  input  logic [31:0]      inst2_IF2,
  output logic             ud_pc_en,
  output logic [IDX_W-1:0] ud_pc_idx,
  output logic [31:0]      ud_pc_data,
  output logic             ud_inst_en,
  output logic [IDX_W-1:0] ud_inst_idx,
  output logic [31:0]      ud_inst_data,
  output logic             busy,
  output logic [7:0]       ovf_cnt,
  output logic [7:0]       tmo_cnt
);

  localparam int PW   = $clog2(DEPTH);
  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

`ifdef BTBC_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE_PC, WAIT_INST} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  mem_idx   [DEPTH];
  logic [31:0]       mem_tgt   [DEPTH];
  logic [IDX_W-1:0]  mem_idx_n [DEPTH];
  logic [31:0]       mem_tgt_n [DEPTH];
  logic [PW-1:0]     rptr, wptr, wptr_n, slot, off;
  logic [PW:0]       count, count_n;
  logic [DEPTH-1:0]  qv;
  logic              hit;
  logic              push0, push1, drop0, drop1, pop;
  logic              match, tmo_hit;
  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_tgt;
  logic [WC_W-1:0]   wait_cnt;
  logic [8:0]        ovf_sum;

  assign req_ready = (count <= (PW+1)'(DEPTH-2));
  assign push0 = req0_valid && req_ready && !flush && (req0_target != '0);
  assign push1 = req1_valid && req_ready && !flush && (req1_target != '0);
  assign drop0 = req0_valid && !req_ready && !flush && (req0_target != '0);
  assign drop1 = req1_valid && !req_ready && !flush && (req1_target != '0);
  assign pop   = (state == IDLE) && (count != '0) && !flush;

  // qv marks entries still queued after this cycle's pop; new slots join it so req1 can hit req0
  always_comb begin
    mem_idx_n = mem_idx;
    mem_tgt_n = mem_tgt;
    wptr_n    = wptr;
    count_n   = count - {{PW{1'b0}}, pop};
    hit       = 1'b0;
    slot      = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off   = PW'(i) - rptr;
      qv[i] = ({1'b0, off} < count) && !(pop && (PW'(i) == rptr));
    end
    if (flush) begin
      wptr_n  = rptr;
      count_n = '0;
    end else begin
      if (push0) begin
        hit  = 1'b0;
        slot = wptr_n;
        for (int i = 0; i < DEPTH; i++)
          if (COALESCE && qv[i] && !hit && mem_idx_n[i] == req0_pc[IDX_W+1:2]) begin
            hit  = 1'b1;
            slot = PW'(i);
          end
        mem_idx_n[slot] = req0_pc[IDX_W+1:2];
        mem_tgt_n[slot] = req0_target;
        qv[slot]        = 1'b1;
        if (!hit) begin
          wptr_n  = wptr_n + 1'b1;
          count_n = count_n + 1'b1;
        end
      end
      if (push1) begin
        hit  = 1'b0;
        slot = wptr_n;
        for (int i = 0; i < DEPTH; i++)
          if (COALESCE && qv[i] && !hit && mem_idx_n[i] == req1_pc[IDX_W+1:2]) begin
            hit  = 1'b1;
            slot = PW'(i);
          end
        mem_idx_n[slot] = req1_pc[IDX_W+1:2];
        mem_tgt_n[slot] = req1_target;
        if (!hit) begin
          wptr_n  = wptr_n + 1'b1;
          count_n = count_n + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    match   = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      IDLE:      if (pop) state_n = WRITE_PC;
      WRITE_PC:  state_n = WAIT_INST;
      WAIT_INST: begin
        if (pc1_IF2 == w_tgt || pc2_IF2 == w_tgt) begin
          match   = 1'b1;
          state_n = IDLE;
        end else if (wait_cnt == WC_W'(TIMEOUT-1)) begin
          tmo_hit = 1'b1;
          state_n = IDLE;
        end
      end
      default:   state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      match   = 1'b0;
      tmo_hit = 1'b0;
    end
  end

  assign ovf_sum = {1'b0, ovf_cnt} + 9'(drop0) + 9'(drop1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_idx[i] <= '0;
        mem_tgt[i] <= '0;
      end
      rptr         <= '0;
      wptr         <= '0;
      count        <= '0;
      state        <= IDLE;
      w_idx        <= '0;
      w_tgt        <= '0;
      wait_cnt     <= '0;
      ud_inst_en   <= 1'b0;
      ud_inst_idx  <= '0;
      ud_inst_data <= '0;
      tmo_cnt      <= '0;
      ovf_cnt      <= '0;
    end else begin
      mem_idx    <= mem_idx_n;
      mem_tgt    <= mem_tgt_n;
      wptr       <= wptr_n;
      count      <= count_n;
      rptr       <= rptr + {{(PW-1){1'b0}}, pop};
      state      <= state_n;
      ud_inst_en <= match;
      if (pop) begin
        w_idx <= mem_idx[rptr];
        w_tgt <= mem_tgt[rptr];
      end
      if (state == WRITE_PC)
        wait_cnt <= '0;
      else if (state == WAIT_INST)
        wait_cnt <= wait_cnt + 1'b1;
      if (match) begin
        ud_inst_data <= (pc1_IF2 == w_tgt) ? inst1_IF2 : inst2_IF2;
        ud_inst_idx  <= w_tgt[IDX_W+1:2];
      end
      if (tmo_hit && tmo_cnt != 8'hff)
        tmo_cnt <= tmo_cnt + 8'd1;
      ovf_cnt <= ovf_sum[8] ? 8'hff : ovf_sum[7:0];
    end
  end

  assign ud_pc_en   = (state == WRITE_PC);
  assign ud_pc_idx  = w_idx;
  assign ud_pc_data = w_tgt;
  assign busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl; BTB PC writes are logged by a monitor and checked in order.
module tb_btb_update_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, flush = 1'b0;
  logic [31:0] req0_pc = '0, req0_target = '0, req1_pc = '0, req1_target = '0;
  logic [31:0] pc1_IF2 = '0, pc2_IF2 = '0, inst1_IF2 = '0, inst2_IF2 = '0;
  logic        req_ready, ud_pc_en, ud_inst_en, busy;
  logic [3:0]  ud_pc_idx, ud_inst_idx;
  logic [31:0] ud_pc_data, ud_inst_data;
  logic [7:0]  ovf_cnt, tmo_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int log_n = 0;
  int base;
  logic [3:0]  log_idx [64];
  logic [31:0] log_dat [64];
  int          log_cyc [64];

  btb_update_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_pc(req0_pc), .req0_target(req0_target),
    .req1_valid(req1_valid), .req1_pc(req1_pc), .req1_target(req1_target),
    .req_ready(req_ready), .flush(flush),
    .pc1_IF2(pc1_IF2), .pc2_IF2(pc2_IF2), .inst1_IF2(inst1_IF2), .inst2_IF2(inst2_IF2),
    .ud_pc_en(ud_pc_en), .ud_pc_idx(ud_pc_idx), .ud_pc_data(ud_pc_data),
    .ud_inst_en(ud_inst_en), .ud_inst_idx(ud_inst_idx), .ud_inst_data(ud_inst_data),
    .busy(busy), .ovf_cnt(ovf_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (ud_pc_en && log_n < 64) begin
      log_idx[log_n] = ud_pc_idx;
      log_dat[log_n] = ud_pc_data;
      log_cyc[log_n] = cyc;
      log_n = log_n + 1;
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic push0(input logic [31:0] pc, input logic [31:0] tgt);
    req0_valid = 1'b1;
    req0_pc = pc;
    req0_target = tgt;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_pc_en", {31'd0, ud_pc_en}, 32'd0);
    chk("rst_inst_en", {31'd0, ud_inst_en}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pc_data", ud_pc_data, 32'd0);
    chk("rst_inst_data", ud_inst_data, 32'd0);
    chk("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
    chk("rst_tmo", {24'd0, tmo_cnt}, 32'd0);
    #20 rst_n = 1'b1;
    step();

    // 1: single request with a lane-2 capture
    push0(32'h40, 32'h100);                 // cycle N
    step(); req0_valid = 1'b0;              // N+1
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_pc_en_n1", {31'd0, ud_pc_en}, 32'd0);
    step();                                 // N+2
    chk("t1_pc_en", {31'd0, ud_pc_en}, 32'd1);
    chk("t1_pc_idx", {28'd0, ud_pc_idx}, 32'd0);
    chk("t1_pc_data", ud_pc_data, 32'h100);
    step();                                 // N+3
    chk("t1_pc_en_n3", {31'd0, ud_pc_en}, 32'd0);
    step();                                 // N+4
    pc2_IF2 = 32'h100; inst2_IF2 = 32'h2402_0005;
    chk("t1_inst_en_n4", {31'd0, ud_inst_en}, 32'd0);
    step();                                 // N+5
    pc2_IF2 = '0; inst2_IF2 = '0;
    chk("t1_inst_en", {31'd0, ud_inst_en}, 32'd1);
    chk("t1_inst_idx", {28'd0, ud_inst_idx}, 32'd0);
    chk("t1_inst_data", ud_inst_data, 32'h2402_0005);
    chk("t1_no_pc_en", {31'd0, ud_pc_en}, 32'd0);
    step();
    chk("t1_inst_en_off", {31'd0, ud_inst_en}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // 2: dual push, both captures time out
    base = log_n;
    push0(32'h44, 32'h200);
    req1_valid = 1'b1; req1_pc = 32'h48; req1_target = 32'h300;
    step(); req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t2_drain");
    chk("t2_nwr", log_n - base, 32'd2);
    chk("t2_idx0", {28'd0, log_idx[base]}, 32'd1);
    chk("t2_dat0", log_dat[base], 32'h200);
    chk("t2_idx1", {28'd0, log_idx[base+1]}, 32'd2);
    chk("t2_dat1", log_dat[base+1], 32'h300);
    chk("t2_spacing", log_cyc[base+1] - log_cyc[base], 32'd10);
    chk("t2_tmo", {24'd0, tmo_cnt}, 32'd2);

    // 3: fill while the FSM waits; one request overflows
    base = log_n;
    push0(32'h50, 32'h400); step();         // K
    push0(32'h54, 32'h404); step();         // K+1
    push0(32'h58, 32'h408); step();         // K+2
    push0(32'h5C, 32'h40C); step();         // K+3
    req0_valid = 1'b0;                      // K+4
    chk("t3_not_ready", {31'd0, req_ready}, 32'd0);
    push0(32'h60, 32'h410); step();
    req0_valid = 1'b0;
    chk("t3_ovf", {24'd0, ovf_cnt}, 32'd1);
    drain("t3_drain");
    chk("t3_nwr", log_n - base, 32'd4);
    chk("t3_first", log_dat[base], 32'h400);
    chk("t3_last_idx", {28'd0, log_idx[base+3]}, 32'd7);
    chk("t3_last_dat", log_dat[base+3], 32'h40C);
    chk("t3_tmo", {24'd0, tmo_cnt}, 32'd6);
    chk("t3_ready", {31'd0, req_ready}, 32'd1);

    // 4: flush in WAIT_INST with 3 queued; flush-cycle push and a zero target are ignored
    push0(32'h64, 32'h500); step();
    push0(32'h68, 32'h504); step();
    push0(32'h6C, 32'h508); step();
    push0(32'h70, 32'h50C); step();
    push0(32'h74, 32'h510);
    flush = 1'b1; pc1_IF2 = 32'h500;
    step();
    flush = 1'b0; pc1_IF2 = '0; req0_valid = 1'b0;
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_inst_en", {31'd0, ud_inst_en}, 32'd0);
    chk("t4_ovf", {24'd0, ovf_cnt}, 32'd1);
    step();
    chk("t4_inst_en2", {31'd0, ud_inst_en}, 32'd0);
    push0(32'h78, 32'h0); step();
    req0_valid = 1'b0;
    chk("t4_zero_busy", {31'd0, busy}, 32'd0);
    chk("t4_zero_ovf", {24'd0, ovf_cnt}, 32'd1);
    chk("t4_tmo", {24'd0, tmo_cnt}, 32'd6);

    // 5: same-index requests queued behind a waiting entry
    base = log_n;
    push0(32'h4C, 32'h700); step();
    push0(32'h40, 32'h100); step();
    push0(32'h80, 32'h500); step();
    req0_valid = 1'b0;
    drain("t5_drain");
    chk("t5_first", log_dat[base], 32'h700);
`ifdef BTBC_COALESCE_EN
    chk("t5_nwr", log_n - base, 32'd2);
    chk("t5_coal_idx", {28'd0, log_idx[base+1]}, 32'd0);
    chk("t5_coal_dat", log_dat[base+1], 32'h500);
    chk("t5_tmo", {24'd0, tmo_cnt}, 32'd8);
`else
    chk("t5_nwr", log_n - base, 32'd3);
    chk("t5_dat1", log_dat[base+1], 32'h100);
    chk("t5_dat2", log_dat[base+2], 32'h500);
    chk("t5_idx2", {28'd0, log_idx[base+2]}, 32'd0);
    chk("t5_tmo", {24'd0, tmo_cnt}, 32'd9);
`endif

    // 6: asynchronous reset during WRITE_PC
    push0(32'h40, 32'h100); step();
    req0_valid = 1'b0; step();
    chk("t6_pc_en", {31'd0, ud_pc_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pc_en_drop", {31'd0, ud_pc_en}, 32'd0);
    chk("t6_ovf", {24'd0, ovf_cnt}, 32'd0);
    chk("t6_tmo", {24'd0, tmo_cnt}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_ready", {31'd0, req_ready}, 32'd1);
    #3 rst_n = 1'b1;
    step();
    chk("t6_after", {31'd0, ud_pc_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
